// File: rtl/axis_arb_pkg.sv
// Shared types for the two-requester AXI-Stream write arbiter:
// FSM states, owner tags and the default data width.
package axis_arb_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_GRANT_S01 = 2'b01,
      ST_GRANT_S02 = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWN_S01 = 1'b0,
      OWN_S02 = 1'b1
   } owner_e;

   function automatic logic [1:0] grant_of(input arb_state_e st);
      logic [1:0] g;
      case (st)
         ST_IDLE:      g = 2'b00;
         ST_GRANT_S01: g = 2'b01;
         ST_GRANT_S02: g = 2'b10;
         default:      g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep forward register for the memory-side stream: loads a beat on
// acceptance and holds it stable until the downstream ready consumes it.
module axis_reg_slice
   import axis_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [DATA_WIDTH/8-1:0] in_strb,
   input  logic                    in_last,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [DATA_WIDTH/8-1:0] out_strb,
   output logic                    out_last
);

   logic                    valid_r;
   logic [DATA_WIDTH-1:0]   data_r;
   logic [DATA_WIDTH/8-1:0] strb_r;
   logic                    last_r;

   // A load always wins: the upstream only loads when the slot is free or draining.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= {DATA_WIDTH{1'b0}};
         strb_r  <= {(DATA_WIDTH/8){1'b0}};
         last_r  <= 1'b0;
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= in_data;
         strb_r  <= in_strb;
         last_r  <= in_last;
      end else if (out_ready) begin
         valid_r <= 1'b0;
      end
   end

   assign out_valid = valid_r;
   assign out_data  = data_r;
   assign out_strb  = strb_r;
   assign out_last  = last_r;

endmodule

// File: rtl/axis_write_arbiter.sv
// Packet-granular round-robin arbiter merging two AXI-Stream requesters onto
// one memory-side stream through a single registered slice.
module axis_write_arbiter
   import axis_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    axis_aclk,
   input  logic                    axis_aresetn,
   input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
   input  logic                    s01_axis_tvalid,
   input  logic                    s01_axis_tlast,
   output logic                    s01_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s02_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s02_axis_tstrb,
   input  logic                    s02_axis_tvalid,
   input  logic                    s02_axis_tlast,
   output logic                    s02_axis_tready,
   output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast,
   input  logic                    m01_axis_tready,
   output logic [1:0]              grant,
   output logic [CNT_WIDTH-1:0]    s01_pkt_cnt,
   output logic [CNT_WIDTH-1:0]    s02_pkt_cnt
);

   arb_state_e              state_r, state_s;
   owner_e                  last_owner_r;
   logic [1:0]              grant_r;
   logic [CNT_WIDTH-1:0]    s01_cnt_r, s02_cnt_r;
   logic                    slot_free_s;
   logic                    s01_ready_s, s02_ready_s;
   logic                    s01_acc_s, s02_acc_s;
   logic [DATA_WIDTH-1:0]   load_data_s;
   logic [DATA_WIDTH/8-1:0] load_strb_s;
   logic                    load_last_s;

   assign slot_free_s = ~m01_axis_tvalid | m01_axis_tready;

   // Arbitration happens only from IDLE; a granted port keeps ownership until its tlast.
   always_comb begin
      state_s     = state_r;
      s01_ready_s = 1'b0;
      s02_ready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (s01_axis_tvalid && s02_axis_tvalid) begin
               state_s = (last_owner_r == OWN_S02) ? ST_GRANT_S01 : ST_GRANT_S02;
            end else if (s01_axis_tvalid) begin
               state_s = ST_GRANT_S01;
            end else if (s02_axis_tvalid) begin
               state_s = ST_GRANT_S02;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GRANT_S01: begin
            s01_ready_s = slot_free_s;
            if (s01_axis_tvalid && slot_free_s && s01_axis_tlast) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GRANT_S01;
            end
         end
         ST_GRANT_S02: begin
            s02_ready_s = slot_free_s;
            if (s02_axis_tvalid && slot_free_s && s02_axis_tlast) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GRANT_S02;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   assign s01_acc_s = s01_axis_tvalid & s01_ready_s;
   assign s02_acc_s = s02_axis_tvalid & s02_ready_s;

   // Beat mux into the output slice; only the owner can ever be accepted.
   always_comb begin
      if (s02_acc_s) begin
         load_data_s = s02_axis_tdata;
         load_strb_s = s02_axis_tstrb;
         load_last_s = s02_axis_tlast;
      end else begin
         load_data_s = s01_axis_tdata;
         load_strb_s = s01_axis_tstrb;
         load_last_s = s01_axis_tlast;
      end
   end

   // State, grant, round-robin history and packet counters (counters wrap).
   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         state_r      <= ST_IDLE;
         grant_r      <= 2'b00;
         last_owner_r <= OWN_S02;
         s01_cnt_r    <= {CNT_WIDTH{1'b0}};
         s02_cnt_r    <= {CNT_WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         grant_r <= grant_of(state_s);
         if (s01_acc_s && s01_axis_tlast) begin
            last_owner_r <= OWN_S01;
            s01_cnt_r    <= s01_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if (s02_acc_s && s02_axis_tlast) begin
            last_owner_r <= OWN_S02;
            s02_cnt_r    <= s02_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   axis_reg_slice #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_slice (
      .clk       (axis_aclk),
      .rst_n     (axis_aresetn),
      .load      (s01_acc_s | s02_acc_s),
      .in_data   (load_data_s),
      .in_strb   (load_strb_s),
      .in_last   (load_last_s),
      .out_ready (m01_axis_tready),
      .out_valid (m01_axis_tvalid),
      .out_data  (m01_axis_tdata),
      .out_strb  (m01_axis_tstrb),
      .out_last  (m01_axis_tlast)
   );

   assign s01_axis_tready = s01_ready_s;
   assign s02_axis_tready = s02_ready_s;
   assign grant           = grant_r;
   assign s01_pkt_cnt     = s01_cnt_r;
   assign s02_pkt_cnt     = s02_cnt_r;

endmodule

// File: tb/tb_axis_write_arbiter.sv
// Randomized bench for axis_write_arbiter: packet queues per requester feed the
// DUT, and a transaction-level model of ownership and the output slot checks it.
module tb_axis_write_arbiter;

   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          axis_aresetn;
   logic [DW-1:0] s01_axis_tdata, s02_axis_tdata, m01_axis_tdata;
   logic [SW-1:0] s01_axis_tstrb, s02_axis_tstrb, m01_axis_tstrb;
   logic          s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
   logic          s02_axis_tvalid, s02_axis_tlast, s02_axis_tready;
   logic          m01_axis_tvalid, m01_axis_tlast, m01_axis_tready;
   logic [1:0]    grant;
   logic [CW-1:0] s01_pkt_cnt, s02_pkt_cnt;

   always #5 clk = ~clk;

   axis_write_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .axis_aclk       (clk),
      .axis_aresetn    (axis_aresetn),
      .s01_axis_tdata  (s01_axis_tdata),
      .s01_axis_tstrb  (s01_axis_tstrb),
      .s01_axis_tvalid (s01_axis_tvalid),
      .s01_axis_tlast  (s01_axis_tlast),
      .s01_axis_tready (s01_axis_tready),
      .s02_axis_tdata  (s02_axis_tdata),
      .s02_axis_tstrb  (s02_axis_tstrb),
      .s02_axis_tvalid (s02_axis_tvalid),
      .s02_axis_tlast  (s02_axis_tlast),
      .s02_axis_tready (s02_axis_tready),
      .m01_axis_tdata  (m01_axis_tdata),
      .m01_axis_tstrb  (m01_axis_tstrb),
      .m01_axis_tvalid (m01_axis_tvalid),
      .m01_axis_tlast  (m01_axis_tlast),
      .m01_axis_tready (m01_axis_tready),
      .grant           (grant),
      .s01_pkt_cnt     (s01_pkt_cnt),
      .s02_pkt_cnt     (s02_pkt_cnt)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic          last;
   } beat_t;

   beat_t q1[$];
   beat_t q2[$];

   int checks = 0;
   int errors = 0;

   // Reference model: owner 0 = nobody, 1 = s01, 2 = s02.
   beat_t m_out;
   bit    m_valid;
   int    owner, last_owner, cnt1, cnt2;

   int vprob1, vprob2, rprob, stall;
   bit arm_stall;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out      = '0;
      m_valid    = 1'b0;
      owner      = 0;
      last_owner = 2;
      cnt1       = 0;
      cnt2       = 0;
   endtask

   task automatic push_pkt(input int port, input int n, input logic [DW-1:0] base, input bit rnd_strb);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = base + DW'(i);
         b.strb = rnd_strb ? SW'($urandom) : 4'hF;
         b.last = (i == n - 1);
         if (port == 1) q1.push_back(b);
         else           q2.push_back(b);
      end
   endtask

   task automatic drive();
      if (!s01_axis_tvalid && q1.size() > 0 && $urandom_range(99) < vprob1) begin
         s01_axis_tvalid = 1'b1;
         {s01_axis_tdata, s01_axis_tstrb, s01_axis_tlast} = q1[0];
      end
      if (!s02_axis_tvalid && q2.size() > 0 && $urandom_range(99) < vprob2) begin
         s02_axis_tvalid = 1'b1;
         {s02_axis_tdata, s02_axis_tstrb, s02_axis_tlast} = q2[0];
      end
      if (arm_stall && m01_axis_tvalid && m01_axis_tdata == 32'hDEADBEEF) begin
         stall     = 5;
         arm_stall = 1'b0;
      end
      if (stall > 0) begin
         m01_axis_tready = 1'b0;
         stall--;
      end else begin
         m01_axis_tready = ($urandom_range(99) < rprob);
      end
   endtask

   // One clock: predict the handshake from the rules, advance the model, compare after the edge.
   task automatic step();
      bit r1, r2, a1, a2, in_rst;
      #1;
      in_rst = !axis_aresetn;
      a1 = 1'b0;
      a2 = 1'b0;
      if (in_rst) begin
         model_reset();
      end else begin
         r1 = (owner == 1) && (!m_valid || m01_axis_tready);
         r2 = (owner == 2) && (!m_valid || m01_axis_tready);
         check_eq("s01_tready", s01_axis_tready, r1);
         check_eq("s02_tready", s02_axis_tready, r2);
         a1 = s01_axis_tvalid && r1;
         a2 = s02_axis_tvalid && r2;
         if (a1 || a2) begin
            m_out   = a1 ? q1.pop_front() : q2.pop_front();
            m_valid = 1'b1;
         end else if (m01_axis_tready) begin
            m_valid = 1'b0;
         end
         if (owner == 0) begin
            if (s01_axis_tvalid && s02_axis_tvalid) owner = (last_owner == 2) ? 1 : 2;
            else if (s01_axis_tvalid)               owner = 1;
            else if (s02_axis_tvalid)               owner = 2;
         end else if ((a1 || a2) && m_out.last) begin
            if (a1) cnt1 = (cnt1 + 1) % (1 << CW);
            else    cnt2 = (cnt2 + 1) % (1 << CW);
            last_owner = owner;
            owner      = 0;
         end
      end
      @(posedge clk);
      #1;
      if (a1) s01_axis_tvalid = 1'b0;
      if (a2) s02_axis_tvalid = 1'b0;
      check_eq("grant", grant, (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
      check_eq("m01_tvalid", m01_axis_tvalid, m_valid);
      if (m_valid || in_rst) begin
         check_eq("m01_tdata", m01_axis_tdata, m_out.data);
         check_eq("m01_tstrb", m01_axis_tstrb, m_out.strb);
         check_eq("m01_tlast", m01_axis_tlast, m_out.last);
      end
      check_eq("s01_pkt_cnt", s01_pkt_cnt, cnt1);
      check_eq("s02_pkt_cnt", s02_pkt_cnt, cnt2);
   endtask

   task automatic apply_reset();
      axis_aresetn    = 1'b0;
      s01_axis_tvalid = 1'b0;
      s02_axis_tvalid = 1'b0;
      m01_axis_tready = 1'b0;
      q1.delete();
      q2.delete();
      stall     = 0;
      arm_stall = 1'b0;
      step();
      axis_aresetn = 1'b1;
   endtask

   task automatic run_drain(input string tag, input int max_cycles);
      int k = 0;
      while ((q1.size() > 0 || q2.size() > 0 || m_valid || owner != 0) && k < max_cycles) begin
         drive();
         step();
         k++;
      end
      check_eq(tag, (k < max_cycles), 1'b1);
   endtask

   initial begin
      axis_aresetn    = 1'b0;
      s01_axis_tdata  = '0;
      s01_axis_tstrb  = '0;
      s01_axis_tlast  = 1'b0;
      s02_axis_tdata  = '0;
      s02_axis_tstrb  = '0;
      s02_axis_tlast  = 1'b0;
      s01_axis_tvalid = 1'b0;
      s02_axis_tvalid = 1'b0;
      m01_axis_tready = 1'b0;
      model_reset();
      apply_reset();
      apply_reset();

      // Single 3-beat packet on s01 with memory always ready.
      vprob1 = 100; vprob2 = 100; rprob = 100;
      push_pkt(1, 3, 32'hA0A0_0000, 1'b0);
      run_drain("single_drain", 20);
      check_eq("single_cnt", s01_pkt_cnt, 4'd1);

      // Contention straight after reset: s01 first, then s02.
      apply_reset();
      push_pkt(1, 2, 32'h1111_0000, 1'b0);
      push_pkt(2, 2, 32'h2222_0000, 1'b0);
      run_drain("contend_drain", 30);
      check_eq("contend_cnt1", s01_pkt_cnt, 4'd1);
      check_eq("contend_cnt2", s02_pkt_cnt, 4'd1);

      // Fairness: both ports saturated with single-beat packets.
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         push_pkt(1, 1, 32'h3100_0000 + 32'(i), 1'b0);
         push_pkt(2, 1, 32'h3200_0000 + 32'(i), 1'b0);
      end
      run_drain("fair_drain", 40);
      check_eq("fair_cnt1", s01_pkt_cnt, 4'd4);
      check_eq("fair_cnt2", s02_pkt_cnt, 4'd4);

      // Backpressure: hold 0xDEADBEEF for 5 cycles mid-packet.
      apply_reset();
      push_pkt(1, 1, 32'h4000_0000, 1'b0);
      q1[0].last = 1'b0;
      push_pkt(1, 1, 32'hDEADBEEF, 1'b0);
      q1[1].last = 1'b0;
      push_pkt(1, 2, 32'h4000_0010, 1'b0);
      arm_stall = 1'b1;
      run_drain("bp_drain", 40);
      check_eq("bp_stall_used", arm_stall, 1'b0);
      check_eq("bp_cnt", s01_pkt_cnt, 4'd1);

      // Reset after 2 of 4 beats, then a fresh packet.
      apply_reset();
      push_pkt(1, 4, 32'h5000_0000, 1'b0);
      begin
         int k = 0;
         while (q1.size() > 2 && k < 20) begin
            drive();
            step();
            k++;
         end
         check_eq("mid_reach", (k < 20), 1'b1);
      end
      axis_aresetn = 1'b0;
      step();
      axis_aresetn    = 1'b1;
      s01_axis_tvalid = 1'b0;
      q1.delete();
      check_eq("mid_rst_ready", s01_axis_tready, 1'b0);
      check_eq("mid_rst_cnt", s01_pkt_cnt, 4'd0);
      push_pkt(1, 3, 32'h5100_0000, 1'b1);
      run_drain("mid_drain", 30);
      check_eq("mid_cnt", s01_pkt_cnt, 4'd1);

      // Counter wrap: 17 packets on s02 with a 4-bit counter.
      apply_reset();
      for (int i = 0; i < 17; i++) push_pkt(2, 1 + (i % 2), 32'h6000_0000 + 32'(i << 4), 1'b0);
      run_drain("wrap_drain", 200);
      check_eq("wrap_cnt", s02_pkt_cnt, 4'd1);

      // Random traffic: gaps, mid-packet valid drops, backpressure, zero strobes.
      apply_reset();
      vprob1 = 55; vprob2 = 45; rprob = 65;
      for (int i = 0; i < 40; i++) begin
         push_pkt(1 + int'($urandom_range(1)), 1 + int'($urandom_range(4)), $urandom, 1'b1);
      end
      run_drain("rand_drain", 4000);
      check_eq("rand_total", (s01_pkt_cnt + s02_pkt_cnt) % 16, 40 % 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_write_arbiter.md
AXIS_WRITE_ARBITER -- requirements
Module: axis_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the tdata width (multiple of 8).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, giving the width of the per-port packet counters.
REQ-003 SHALL have port axis_aclk, input, 1 bit: the single clock.
REQ-004 SHALL have port axis_aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports s01_axis_tdata/tstrb/tvalid/tlast, input, widths DATA_WIDTH/DATA_WIDTH/8/1/1: requester 1 stream.
REQ-006 SHALL have port s01_axis_tready, output, 1 bit: requester 1 ready.
REQ-007 SHALL have ports s02_axis_tdata/tstrb/tvalid/tlast, input, widths as REQ-005: requester 2 stream.
REQ-008 SHALL have port s02_axis_tready, output, 1 bit: requester 2 ready.
REQ-009 SHALL have ports m01_axis_tdata/tstrb/tvalid/tlast, output, widths as REQ-005: memory-side stream.
REQ-010 SHALL have port m01_axis_tready, input, 1 bit: memory ready.
REQ-011 SHALL have port grant, output, 2 bits: one-hot current owner (01 = s01, 10 = s02, 00 = none).
REQ-012 SHALL have ports s01_pkt_cnt and s02_pkt_cnt, output, CNT_WIDTH each: forwarded-packet counts.

Function
REQ-013 SHALL implement states IDLE, GRANT_S01 and GRANT_S02; grant SHALL be 00, 01 and 10 respectively.
REQ-014 IDLE SHALL hold both s0x_axis_tready low.
REQ-015 IDLE with exactly one sx_tvalid high SHALL go to that port's GRANT state on the next edge.
REQ-016 IDLE with both tvalid high SHALL grant the port not recorded in last_owner (round-robin); last_owner SHALL reset to s02 so s01 wins first.
REQ-017 GRANT_Sx SHALL drive sx_tready = ~m01_axis_tvalid | m01_axis_tready; the other port's tready SHALL be 0.
REQ-018 A beat is accepted on the slave side when sx_tvalid & sx_tready; it SHALL be registered into the m01 outputs (tdata, tstrb, tlast, tvalid=1) on that edge, giving 1-cycle latency.
REQ-019 m01_axis_tvalid SHALL clear on the edge where m01_axis_tready is high and no new beat is accepted; m01 data SHALL hold stable while tvalid & ~tready.
REQ-020 Accepting a beat with tlast=1 SHALL move the FSM to IDLE, set last_owner to that port, and increment that port's pkt_cnt by 1, wrapping modulo 2^CNT_WIDTH.
REQ-021 The FSM SHALL re-arbitrate only from IDLE, so there is a mandatory one-cycle gap of ready-low between packets.
REQ-022 Ownership SHALL be packet-granular: a non-granted port's tvalid SHALL never preempt a packet in progress.
REQ-023 Beats with tstrb = 0 SHALL be forwarded unmodified; the block SHALL NOT filter on tstrb.
REQ-024 The FSM SHALL NOT wait for the final m01 beat to drain before leaving GRANT; the next packet's first beat waits via REQ-017.
REQ-025 Granted sx_tvalid dropping mid-packet SHALL keep ownership, with no timeout.

Reset
REQ-026 While axis_aresetn = 0 at an edge: state = IDLE, grant = 00, all s tready = 0, m01 tvalid/tlast = 0, m01 tdata/tstrb = 0 (never Z), pkt_cnt = 0, last_owner = s02.
REQ-027 Reset mid-packet SHALL discard the held beat and the partial packet with no count increment; behaviour SHALL resume from IDLE on the first edge after release.

Structure
REQ-028 Package axis_arb_pkg SHALL hold the FSM state enum, the owner enum (OWN_S01, OWN_S02) and the default DATA_WIDTH constant.
REQ-029 The m01 output register of REQ-018/019 SHALL be sub-module axis_reg_slice, parameterised on DATA_WIDTH; the arbiter FSM and counters stay in the top.

Verification
REQ-030 Single packet: s01 sends 3 beats A0,A1,A2 (tlast on A2) with m01_tready=1 -> m01 shows A0..A2 each one cycle after acceptance, grant=01, s01_pkt_cnt=1, then IDLE.
REQ-031 Contention: s01 and s02 both assert valid in IDLE after reset -> s01 granted first; its 2-beat packet completes, then s02's packet follows after exactly one idle cycle; both counts = 1.
REQ-032 Fairness: both ports continuously valid, 1-beat packets, for 8 packets -> grant alternates 01,10,01...; each count = 4.
REQ-033 Backpressure: m01_tready low for 5 cycles mid-packet with data 0xDEADBEEF held -> m01_tdata stable, s01_tready=0, no beat lost or duplicated.
REQ-034 Reset mid-packet: assert axis_aresetn=0 after 2 of 4 beats -> all outputs at REQ-026 values next edge, counts 0, new packet then forwards normally.
REQ-035 Wrap: CNT_WIDTH=4, 17 packets on s02 -> s02_pkt_cnt=1.
